// File: rtl/sequence_generator_tx.sv
// sequence_generator_tx: parallel-to-serial transmitter for the bit-stream link.
// Words enter through a valid/ready handshake and leave MSB-first on x, one bit
// per clock. A line monitor counts every "110" seen on x (idle zeros included)
// so a downstream sequence detector's hit count can be cross-checked.
module sequence_generator_tx #(
  parameter int WIDTH = 8,  // bits per parallel word (>=1)
  parameter int CNT_W = 8   // width of the saturating pattern counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] pat_cnt
);

  // Bit counter width; a 1-bit word still gets a 1-bit counter.
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;     // bits still to send, next bit at the MSB
  logic [BCW-1:0]   bit_cnt;   // bits remaining after the one now on x
  logic [1:0]       hist;      // x one cycle ago in [0], two cycles ago in [1]
  logic             accept;
  logic             load;
  logic             shift_en;
  logic             hit;

  // Ready depends only on registered state, so there is no path from din_valid.
  // In SHIFT, last is high exactly on the final-bit cycle of a word.
  always_comb begin
    din_ready = (state == IDLE) | ((state == SHIFT) & last);
    busy      = (state == SHIFT);
    accept    = din_valid & din_ready;
  end

  // Next-state and datapath-control decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (last) begin
          // Final bit on the line: reload for a zero-gap follow-on word, or stop.
          if (accept) load      = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          shift_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Shift datapath: the serial outputs are registered, so the MSB appears the
  // cycle after acceptance and the line drops to 0 whenever no bit is sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      last    <= 1'b0;
    end else if (load) begin
      x       <= din[WIDTH-1];
      shreg   <= din << 1;
      bit_cnt <= BCW'(WIDTH - 1);
      x_valid <= 1'b1;
      last    <= (WIDTH == 1);
    end else if (shift_en) begin
      x       <= shreg[WIDTH-1];
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt - BCW'(1);
      last    <= (bit_cnt == BCW'(1));
    end else begin
      x       <= 1'b0;
      x_valid <= 1'b0;
      last    <= 1'b0;
    end
  end

  // A "110" completes when the current bit is 0 and the two before it were 1.
  always_comb hit = ~x & (hist == 2'b11);

  // Line monitor: history follows x every cycle; the count saturates, and a
  // clear wins over a same-cycle hit but leaves the history intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist    <= 2'b00;
      pat_cnt <= '0;
    end else begin
      hist <= {hist[0], x};
      if (clr_cnt)                  pat_cnt <= '0;
      else if (hit && ~&pat_cnt)    pat_cnt <= pat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sequence_generator_tx.sv
// Directed bench for sequence_generator_tx: serial framing, handshake, reset
// abort, pattern counting with saturation/clear, and the 1-bit-word streaming case.
module tb_sequence_generator_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       clr_cnt;

  logic       din_ready, x, x_valid, last, busy;
  logic [7:0] pat_cnt;

  logic       s_ready, s_x, s_xv, s_last, s_busy;
  logic [1:0] s_pat;

  logic       w_din, w_valid;
  logic       w_ready, w_x, w_xv, w_last, w_busy;
  logic [7:0] w_pat;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sequence_generator_tx #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .x(x), .x_valid(x_valid), .last(last), .busy(busy), .clr_cnt(clr_cnt), .pat_cnt(pat_cnt)
  );

  sequence_generator_tx #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(s_ready),
    .x(s_x), .x_valid(s_xv), .last(s_last), .busy(s_busy), .clr_cnt(clr_cnt), .pat_cnt(s_pat)
  );

  sequence_generator_tx #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .din(w_din), .din_valid(w_valid), .din_ready(w_ready),
    .x(w_x), .x_valid(w_xv), .last(w_last), .busy(w_busy), .clr_cnt(clr_cnt), .pat_cnt(w_pat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnt();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  // Present a word and hold it until the edge that accepts it; returns in the
  // cycle that carries the MSB.
  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    din       = w;
    din_valid = 1'b1;
    while (!din_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(din_ready), 32'(1));
    tick();
    din_valid = 1'b0;
    din       = 8'($urandom);
  endtask

  // Check all 8 bit cycles of a word; clr_at selects a cycle in which to pulse clr_cnt.
  task automatic expect_word(input string tag, input logic [7:0] w, input int clr_at);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_x%0d", tag, i), 32'(x), 32'(w[7-i]));
      check($sformatf("%s_xv%0d", tag, i), 32'(x_valid), 32'(1));
      check($sformatf("%s_last%0d", tag, i), 32'(last), 32'(i == 7));
      check($sformatf("%s_rdy%0d", tag, i), 32'(din_ready), 32'(i == 7));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'(1));
      clr_cnt = (i == clr_at);
      tick();
    end
    clr_cnt = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_x"}, 32'(x), 32'(0));
    check({tag, "_xv"}, 32'(x_valid), 32'(0));
    check({tag, "_last"}, 32'(last), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_rdy"}, 32'(din_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wbits;
    rst       = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    w_din     = 1'b0;
    w_valid   = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    // T1: reset held two cycles while idle.
    rst = 1'b1;
    tick();
    check("t1_rdy_in_rst", 32'(din_ready), 32'(1));
    tick();
    rst = 1'b0;
    expect_idle("t1");
    check("t1_pat", 32'(pat_cnt), 32'(0));

    // T2: single word, two overlapping-free "110" hits.
    send(8'b1101_0110);
    expect_word("t2", 8'b1101_0110, -1);
    expect_idle("t2_after");
    check("t2_pat", 32'(pat_cnt), 32'(2));
    clear_cnt();
    check("t2_clr", 32'(pat_cnt), 32'(0));

    // T3: back-to-back FF then 00; din toggles freely while not ready.
    din       = 8'hFF;
    din_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      din = (i == 7) ? 8'h00 : 8'($urandom);
      check($sformatf("t3a_x%0d", i), 32'(x), 32'(1));
      check($sformatf("t3a_xv%0d", i), 32'(x_valid), 32'(1));
      check($sformatf("t3a_rdy%0d", i), 32'(din_ready), 32'(i == 7));
      tick();
    end
    din_valid = 1'b0;
    expect_word("t3b", 8'h00, -1);
    expect_idle("t3_after");
    check("t3_pat", 32'(pat_cnt), 32'(1));
    clear_cnt();

    // T4: trailing "11" followed by idle counts at the end of the first idle cycle.
    send(8'b0000_0011);
    expect_word("t4", 8'b0000_0011, -1);
    check("t4_pat_before", 32'(pat_cnt), 32'(0));
    tick();
    check("t4_pat_after", 32'(pat_cnt), 32'(1));
    clear_cnt();

    // Clear on the final bit cycle leaves the history, so the idle 0 still counts.
    send(8'b0000_0011);
    expect_word("t4h", 8'b0000_0011, 7);
    check("t4h_cleared", 32'(pat_cnt), 32'(0));
    tick();
    check("t4h_counted", 32'(pat_cnt), 32'(1));
    clear_cnt();

    // T5: reset during bit 4 of AA aborts the word.
    send(8'hAA);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_x%0d", i), 32'(x), 32'(i % 2 == 0));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle("t5_rst");
    check("t5_pat_rst", 32'(pat_cnt), 32'(0));
    repeat (3) tick();
    expect_idle("t5_quiet");
    send(8'hC0);
    expect_word("t5c", 8'hC0, -1);
    check("t5_pat", 32'(pat_cnt), 32'(1));

    // T6: two DB words back-to-back then idle: 5 hits, 2-bit counter saturates at 3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din       = 8'b1101_1011;
    din_valid = 1'b1;
    tick();
    repeat (8) tick();
    din_valid = 1'b0;
    check("t6_sat_mid", 32'(s_pat), 32'(2));
    check("t6_xv_mid", 32'(s_xv), 32'(1));
    repeat (8) tick();
    check("t6_sat_end", 32'(s_pat), 32'(3));
    check("t6_xv_end", 32'(s_xv), 32'(0));
    tick();
    check("t6_sat_hold", 32'(s_pat), 32'(3));
    check("t6_wide", 32'(pat_cnt), 32'(5));
    // Clear in the cycle of a hit (x=0 after "11" in C0) wins.
    send(8'hC0);
    expect_word("t6c", 8'hC0, 2);
    check("t6_sat_clr", 32'(s_pat), 32'(0));
    check("t6_wide_clr", 32'(pat_cnt), 32'(0));

    // WIDTH=1: one word per clock while din_valid stays high.
    wbits   = 8'b1101_0011;
    w_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_din = wbits[7-i];
      check($sformatf("w1_rdy%0d", i), 32'(w_ready), 32'(1));
      tick();
      check($sformatf("w1_x%0d", i), 32'(w_x), 32'(wbits[7-i]));
      check($sformatf("w1_xv%0d", i), 32'(w_xv), 32'(1));
      check($sformatf("w1_last%0d", i), 32'(w_last), 32'(1));
    end
    w_valid = 1'b0;
    tick();
    check("w1_idle_xv", 32'(w_xv), 32'(0));
    check("w1_pat_a", 32'(w_pat), 32'(1));
    tick();
    check("w1_pat_b", 32'(w_pat), 32'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
